// File: rtl/iq_exe_sched.sv
// Execution-unit scheduler for the 3-entry issue queue: per-unit busy countdowns,
// ready/done generation, protocol checking and a RUN/FLUSH/DRAIN flush sequencer.
module iq_exe_sched #(
    parameter int unsigned LAT0 = 3,
    parameter int unsigned LAT1 = 1,
    parameter int unsigned CW   = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [2:0] issue0,
    input  logic [2:0] issue1,
    input  logic       stall,
    input  logic [2:0] kill,
    input  logic       flush_req,
    output logic [1:0] exe_ready,
    output logic [2:0] flush,
    output logic [1:0] done,
    output logic [1:0] busy,
    output logic       quiesced,
    output logic       protocol_err
);

    typedef enum logic [1:0] {StRun, StFlush, StDrain} state_e;

    localparam logic [CW-1:0] Lat0C = CW'(LAT0);
    localparam logic [CW-1:0] Lat1C = CW'(LAT1);
    localparam logic [CW-1:0] OneC  = CW'(1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic          err_q, err_d;

    logic run, cnt0_zero, cnt1_zero;
    logic onehot0, onehot1, overlap, acc0, acc1, viol;

    always_comb begin
        run       = reset_n && (state_q == StRun);
        cnt0_zero = (cnt0_q == '0);
        cnt1_zero = (cnt1_q == '0);

        exe_ready[0] = run && !stall && (cnt0_q <= OneC);
        exe_ready[1] = run && !stall && (cnt1_q <= OneC);
        done[0]      = run && (cnt0_q == OneC);
        done[1]      = run && (cnt1_q == OneC);
        busy         = {!cnt1_zero, !cnt0_zero};
        quiesced     = run && cnt0_zero && cnt1_zero;
        protocol_err = err_q;

        if (!reset_n)                flush = 3'b111;
        else if (state_q == StRun)   flush = kill;
        else if (state_q == StFlush) flush = 3'b111;
        else                         flush = 3'b000;
    end

    // Any illegal grant blocks the load of the unit(s) it targets.
    always_comb begin
        onehot0 = ((issue0 & (issue0 - 3'd1)) == 3'b000);
        onehot1 = ((issue1 & (issue1 - 3'd1)) == 3'b000);
        overlap = ((issue0 & issue1) != 3'b000);
        acc0    = (issue0 != 3'b000) && exe_ready[0] && onehot0 && !overlap;
        acc1    = (issue1 != 3'b000) && exe_ready[1] && onehot1 && !overlap;
        viol    = ((issue0 != 3'b000) && !exe_ready[0]) ||
                  ((issue1 != 3'b000) && !exe_ready[1]) ||
                  !onehot0 || !onehot1 || overlap;
        err_d   = err_q || viol;

        if (acc0)            cnt0_d = Lat0C;
        else if (!cnt0_zero) cnt0_d = cnt0_q - OneC;
        else                 cnt0_d = cnt0_q;

        if (acc1)            cnt1_d = Lat1C;
        else if (!cnt1_zero) cnt1_d = cnt1_q - OneC;
        else                 cnt1_d = cnt1_q;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:   if (flush_req) state_d = StFlush;
            StFlush: state_d = StDrain;
            StDrain: if (cnt0_zero && cnt1_zero) state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= StRun;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_iq_exe_sched.sv
// Randomized bench for iq_exe_sched against a timestamp-based model: each unit is
// described by the cycle its current op completes, and flush by a simple phase.
module tb_iq_exe_sched;

    localparam int LAT0 = 3;
    localparam int LAT1 = 1;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [2:0] issue0, issue1, kill;
    logic       stall, flush_req;
    logic [1:0] exe_ready, done, busy;
    logic [2:0] flush;
    logic       quiesced, protocol_err;

    int n_tests = 0;
    int n_fail  = 0;

    iq_exe_sched #(.LAT0(LAT0), .LAT1(LAT1), .CW(4)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .issue0      (issue0),
        .issue1      (issue1),
        .stall       (stall),
        .kill        (kill),
        .flush_req   (flush_req),
        .exe_ready   (exe_ready),
        .flush       (flush),
        .done        (done),
        .busy        (busy),
        .quiesced    (quiesced),
        .protocol_err(protocol_err)
    );

    always #5 clock = ~clock;

    int cyc;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Model: td[k] = cycle in which unit k's latest op completes; phase 0 run, 1 flush, 2 drain.
    int   td0, td1, phase;
    logic m_err;

    function automatic logic [2:0] rand_onehot();
        return 3'b001 << $urandom_range(2, 0);
    endfunction

    initial begin
        logic run, r0, r1;
        logic [1:0] e_ready, e_done, e_busy;
        logic [2:0] e_flush;
        logic e_q;
        logic oh0, oh1, ovl, acc0, acc1;

        td0 = -10; td1 = -10; phase = 0; m_err = 1'b0;
        reset_n = 1'b0; issue0 = '0; issue1 = '0; kill = '0; stall = 1'b0; flush_req = 1'b0;

        for (cyc = 0; cyc < 1500; cyc++) begin
            @(posedge clock);
            #1;
            // Stimulus: resets at segment starts and occasionally mid-run.
            reset_n   = !((cyc % 250) < 2 || $urandom_range(99, 0) == 0);
            stall     = ($urandom_range(7, 0) == 0);
            flush_req = ($urandom_range(11, 0) == 0);
            kill      = 3'($urandom);
            run = reset_n && (phase == 0);
            r0  = run && !stall && (cyc >= td0);
            r1  = run && !stall && (cyc >= td1);
            issue0 = (r0 && $urandom_range(1, 0) == 1) ? rand_onehot() : 3'b000;
            issue1 = (r1 && $urandom_range(1, 0) == 1) ? rand_onehot() : 3'b000;
            if ((issue0 & issue1) != 3'b000) issue1 = 3'b000;
            if ($urandom_range(24, 0) == 0) issue0 = 3'($urandom);
            if ($urandom_range(24, 0) == 0) issue1 = 3'($urandom);

            #3;
            e_ready = {r1, r0};
            e_done  = {run && (cyc == td1), run && (cyc == td0)};
            e_busy  = {cyc <= td1, cyc <= td0};
            e_q     = run && (cyc > td0) && (cyc > td1);
            if (!reset_n)        e_flush = 3'b111;
            else if (phase == 0) e_flush = kill;
            else if (phase == 1) e_flush = 3'b111;
            else                 e_flush = 3'b000;

            check("exe_ready", 8'(exe_ready), 8'(e_ready));
            check("flush", 8'(flush), 8'(e_flush));
            check("done", 8'(done), 8'(e_done));
            check("busy", 8'(busy), 8'(e_busy));
            check("quiesced", 8'(quiesced), 8'(e_q));
            check("protocol_err", 8'(protocol_err), 8'(m_err));

            // Model update for the coming edge.
            if (!reset_n) begin
                td0 = -10; td1 = -10; phase = 0; m_err = 1'b0;
            end else begin
                oh0  = ($countones(issue0) <= 1);
                oh1  = ($countones(issue1) <= 1);
                ovl  = ((issue0 & issue1) != 3'b000);
                acc0 = (issue0 != 3'b000) && r0 && oh0 && !ovl;
                acc1 = (issue1 != 3'b000) && r1 && oh1 && !ovl;
                if (((issue0 != 3'b000) && !r0) || ((issue1 != 3'b000) && !r1) ||
                    !oh0 || !oh1 || ovl)
                    m_err = 1'b1;
                if (phase == 0 && flush_req)                    phase = 1;
                else if (phase == 1)                            phase = 2;
                else if (phase == 2 && cyc > td0 && cyc > td1)  phase = 0;
                if (acc0) td0 = cyc + LAT0;
                if (acc1) td1 = cyc + LAT1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/iq_exe_sched.md
Name: iq_exe_sched

Overview:
- Execution-unit scheduler for the 3-entry instruction issue queue.
- Generates the queue's exe_ready[1:0] and flush[2:0] controls.
- Consumes the queue's issue0/issue1 grant vectors and tracks two non-pipelined multi-cycle execution units with per-unit countdown timers.
- Sequences a global pipeline flush through a RUN/FLUSH/DRAIN state machine so the queue is never issued into a unit that still holds a killed operation.

Parameters:
- LAT0, 3, execution latency of unit 0 in cycles (>=1).
- LAT1, 1, execution latency of unit 1 in cycles (>=1).
- CW, 4, busy-counter width; must satisfy 2^CW > max(LAT0, LAT1).

Ports:
- clock  in  1  single system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- issue0  in  3  queue grant to unit 0, one-hot or zero, bit i = entry i.
- issue1  in  3  queue grant to unit 1, one-hot or zero.
- stall  in  1  back-end stall; forces exe_ready low.
- kill  in  3  selective per-entry squash request, passed to flush in RUN.
- flush_req  in  1  global flush request (level, sampled each cycle).
- exe_ready  out  2  per-unit ready to the queue.
- flush  out  3  per-entry flush to the queue.
- done  out  2  per-unit completion pulse.
- busy  out  2  per-unit counter nonzero.
- quiesced  out  1  RUN and both counters zero.
- protocol_err  out  1  sticky protocol violation flag.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low (clock, reset_n).
- Reset (reset_n low at a rising edge):
  - state=RUN, cnt0=cnt1=0, protocol_err=0.
  - While reset_n is low, outputs are forced to exe_ready=00, flush=111, done=00, quiesced=0.
  - Reset asserted mid-operation discards in-flight ops; no done pulse is produced for them.
- Accept rule:
  - Unit k accepts in cycle N iff exe_ready[k]=1 and issueK!=0.
  - At the edge ending N, cnt_k loads LATk.
  - Otherwise cnt_k decrements when nonzero.
- exe_ready[k] = (state==RUN) & ~stall & (cnt_k<=1). A new op may therefore be accepted in the completion cycle; throughput is one op per LATk cycles.
- done[k] = (cnt_k==1) & (state==RUN).
  - Op accepted in cycle N completes with done in cycle N+LATk.
  - LATk=1 gives done in N+1 with back-to-back accepts.
- Accept while cnt_k==1: done pulses that cycle and cnt_k reloads LATk (simultaneous completion and issue).
- busy[k] = (cnt_k!=0).
- quiesced = (state==RUN) & (cnt0==0) & (cnt1==0).
- protocol_err (sticky until reset) sets on any of:
  - issueK nonzero while exe_ready[k]=0;
  - issueK not one-hot-or-zero;
  - (issue0 & issue1) != 0.
  - An illegal issue never loads a counter.
- State machine:
  - RUN:
    - flush = kill; exe_ready as above.
    - flush_req=1 -> FLUSH. Grants in that same cycle are still accepted normally.
  - FLUSH (exactly one cycle):
    - flush=111, exe_ready=00, done=00.
    - Counters keep decrementing.
    - -> DRAIN.
  - DRAIN:
    - flush=000, exe_ready=00, done=00 (killed ops complete silently).
    - Counters keep decrementing.
    - -> RUN when cnt0==0 and cnt1==0. If both counters are already zero on entry, DRAIN lasts one cycle.
  - flush_req during FLUSH/DRAIN is ignored.
  - flush_req still high on return to RUN starts a new flush next cycle.
- Priority: reset > state-machine control > stall. kill is ignored outside RUN.
- Counter arithmetic: unsigned CW bits, never wraps. Decrement occurs only when nonzero.

Test Plan:
- Reset then idle, LAT0=3, LAT1=1 -> exe_ready=11 and quiesced=1 from first post-reset cycle; flush=111 while reset_n=0.
- issue0=001 at cycle 5 -> exe_ready[0]=0 in cycles 6-7, done[0]=1 and exe_ready[0]=1 in cycle 8; issue0=010 in cycle 8 -> done[0] at cycle 11, no gap.
- issue1=100 every cycle, stall=0 -> done[1] high every cycle from second cycle, busy[1]=1 throughout, protocol_err=0.
- issue0=001 at cycle 5, flush_req pulse at cycle 6 -> flush=111 cycle 7, DRAIN cycles 8..(≥8) until cnt0=0, no done pulse at 8, RUN and exe_ready=11 resume after cnt0 hits zero.
- stall=1 with issue0=010 presented -> exe_ready=00, protocol_err=1 next cycle and stays 1 until reset; cnt0 unchanged.
- kill=010 in RUN -> flush=010 same cycle; kill=010 during DRAIN -> flush=000.
